rd_control: RTL

Readback controller for the configuration register bank, the transmit-side counterpart of the write controller. On `start_rd` it snapshots the parallel configuration word and streams it, one byte at a time, to the UART transmitter using a `tx_start`/`tx_busy` handshake, then pulses `done_rd`. It sits between the configuration registers and the UART TX block and drives three status LEDs.

---
 rtl/rd_pkg.sv | 26 ++
 rtl/rd_control_shift.sv | 47 ++++
 rtl/rd_control.sv | 119 +++++++++++
 3 files changed

// File: rtl/rd_pkg.sv
// Shared definitions for the configuration readback controller: state encodings,
// LED codes and the default configuration byte count shared with the write side.
package rd_pkg;

    localparam int N_BYTES_DEF = 11;
    localparam int CNT_W_DEF   = 4;

    // Encodings double as the LED codes, so decode is a straight copy for legal states.
    typedef enum logic [2:0] {
        ST_START     = 3'b001,
        ST_LOAD      = 3'b010,
        ST_SEND      = 3'b011,
        ST_WAIT_ACK  = 3'b100,
        ST_WAIT_DONE = 3'b101,
        ST_DONE      = 3'b110
    } rd_state_t;

    localparam logic [2:0] LED_START     = 3'b001;
    localparam logic [2:0] LED_LOAD      = 3'b010;
    localparam logic [2:0] LED_SEND      = 3'b011;
    localparam logic [2:0] LED_WAIT_ACK  = 3'b100;
    localparam logic [2:0] LED_WAIT_DONE = 3'b101;
    localparam logic [2:0] LED_DONE      = 3'b110;
    localparam logic [2:0] LED_ILLEGAL   = 3'b111;

endpackage

// File: rtl/rd_control_shift.sv
// Byte-wide shift register holding the captured configuration snapshot.
// Parallel load, left shift by one byte, and exposes the top two bytes.
module rd_control_shift #(
    parameter int N_BYTES = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic [8*N_BYTES-1:0] i_data,
    output logic [7:0]           o_top,
    output logic [7:0]           o_next
);

    localparam int W = 8 * N_BYTES;

    logic [W-1:0] r_data;

    generate
        if (N_BYTES > 1) begin : g_multi
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data <= '0;
                end else if (i_load) begin
                    r_data <= i_data;
                end else if (i_shift) begin
                    r_data <= {r_data[W-9:0], 8'h00};
                end
            end
            assign o_next = r_data[W-9 -: 8];
        end else begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data <= '0;
                end else if (i_load) begin
                    r_data <= i_data;
                end else if (i_shift) begin
                    r_data <= '0;
                end
            end
            assign o_next = 8'h00;
        end
    endgenerate

    assign o_top = r_data[W-1 -: 8];

endmodule

// File: rtl/rd_control.sv
// Configuration readback controller: snapshots the config bank on request and
// streams it MSB byte first to the UART transmitter via tx_start/tx_busy.
module rd_control
    import rd_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_rd,
    input  logic [8*N_BYTES-1:0] conf_data,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 done_rd,
    output logic [2:0]           rd_leds
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

    rd_state_t        r_state;
    rd_state_t        w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_tx_data;
    logic [7:0]       w_top;
    logic [7:0]       w_next_byte;
    logic             w_capture;
    logic             w_last;
    logic             w_first_send;
    logic             w_advance;

    assign w_capture    = (r_state == ST_START) && start_rd;
    assign w_last       = (r_count == LAST_IDX);
    assign w_first_send = (r_state == ST_LOAD) && !tx_busy;
    assign w_advance    = (r_state == ST_WAIT_DONE) && !tx_busy && !w_last;

    rd_control_shift #(
        .N_BYTES (N_BYTES)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_capture),
        .i_shift (w_advance),
        .i_data  (conf_data),
        .o_top   (w_top),
        .o_next  (w_next_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_START:     if (start_rd) w_next_state = ST_LOAD;
            ST_LOAD:      if (!tx_busy) w_next_state = ST_SEND;
            ST_SEND:      w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (tx_busy) w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = w_last ? ST_DONE : ST_SEND;
                end
            end
            ST_DONE:      w_next_state = ST_START;
            default:      w_next_state = ST_START;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        done_rd  = 1'b0;
        rd_leds  = LED_ILLEGAL;
        case (r_state)
            ST_START:     rd_leds = LED_START;
            ST_LOAD:      rd_leds = LED_LOAD;
            ST_SEND: begin
                rd_leds  = LED_SEND;
                tx_start = 1'b1;
            end
            ST_WAIT_ACK:  rd_leds = LED_WAIT_ACK;
            ST_WAIT_DONE: rd_leds = LED_WAIT_DONE;
            ST_DONE: begin
                rd_leds = LED_DONE;
                done_rd = 1'b1;
            end
            default:      rd_leds = LED_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_capture) begin
            r_count <= '0;
        end else if (w_advance) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // The shift happens on the same edge as the reload, so the next byte is taken one slot down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_data <= 8'h00;
        end else if (w_first_send) begin
            r_tx_data <= w_top;
        end else if (w_advance) begin
            r_tx_data <= w_next_byte;
        end
    end

    assign tx_data = r_tx_data;

endmodule
